// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, mode encoding and the
// SubBytes engine state encoding.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index 0 is the leftmost byte of the concatenation below.
  typedef logic [0:255][7:0] sbox_t;

  localparam sbox_t SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse table is derived from the forward table so the pair
  // is an exact inverse by construction.
  function automatic sbox_t invert_sbox(input sbox_t fwd);
    sbox_t inv;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      inv[fwd[i]] = 8'(i);
    end
    return inv;
  endfunction

  localparam sbox_t SBOX_INV = invert_sbox(SBOX_FWD);

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: byte in, byte out, forward or inverse.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       mode,
  output logic [7:0] dout
);

  assign dout = (mode == MODE_INV) ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes engine: accepts a state word, pushes
// LANES bytes per cycle through the S-box lanes, then offers the result.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
);

  localparam int SAFE_LANES = (LANES > 0) ? LANES : 1;
  localparam int STEPS      = NUM_BYTES / SAFE_LANES;
  localparam int CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int W          = 8 * NUM_BYTES;
  localparam bit PARAMS_OK  = (LANES >= 1) && (LANES <= NUM_BYTES) &&
                              ((NUM_BYTES % SAFE_LANES) == 0);

  if (!PARAMS_OK) begin : g_bad_params
    $error("aes_sub_bytes_iter: NUM_BYTES must be a non-zero multiple of LANES");
  end

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   mode_reg;
  logic [W-1:0]           work_reg;
  logic [W-1:0]           work_sub;
  logic [W-1:0]           out_data_reg;
  logic                   in_ready_reg, out_valid_reg, busy_reg;
  logic [STEPS-1:0][8*SAFE_LANES-1:0] work_groups;
  logic [8*SAFE_LANES-1:0]            group_sel;
  logic [SAFE_LANES-1:0][7:0]         lane_out;
  logic                   accept;
  logic                   last_step;

  assign work_groups = work_reg;
  assign accept      = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign last_step   = (cnt_reg == CNT_W'(STEPS - 1));

  // The byte group currently being substituted is picked by the counter.
  if (STEPS == 1) begin : g_one_group
    assign group_sel = work_reg;
  end else begin : g_many_groups
    assign group_sel = work_groups[cnt_reg];
  end

  genvar gi;
  for (gi = 0; gi < SAFE_LANES; gi++) begin : g_lane
    aes_sbox_lane u_lane (
      .din  (group_sel[8*gi +: 8]),
      .mode (mode_reg),
      .dout (lane_out[gi])
    );
  end

  // Only the bytes of the active group take the lane output.
  for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    localparam int GROUP = gi / SAFE_LANES;
    localparam int LANE  = gi % SAFE_LANES;
    assign work_sub[8*gi +: 8] = (cnt_reg == CNT_W'(GROUP)) ? lane_out[LANE]
                                                            : work_reg[8*gi +: 8];
  end

  // Next-state decode for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mode_reg      <= MODE_FWD;
      work_reg      <= '0;
      out_data_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
      busy_reg      <= (state_next != IDLE);
      if (accept) begin
        work_reg <= in_data;
        mode_reg <= in_mode;
        cnt_reg  <= '0;
      end else if (state_reg == BUSY) begin
        work_reg <= work_sub;
        cnt_reg  <= last_step ? '0 : cnt_reg + CNT_W'(1);
        if (last_step) begin
          out_data_reg <= work_sub;
        end
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;

endmodule
